// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: control codes, aluop classes
// and the funct3 values the decoder recognises.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_SUB     = 4'd3;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_e;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational translation of (aluop, funct3, funct7[5]) into the ALU
// control code. Anything not recognised maps to the ILLEGAL code.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        aluop,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  output logic [CTRL_W-1:0] control,
  output logic              illegal
);

  // Decode the instruction class, then funct3 within R/I classes.
  always_comb begin
    control = CTRL_W'(ALU_ILLEGAL);
    case (aluop)
      ALUOP_MEM: control = CTRL_W'(ALU_ADD);
      ALUOP_BR:  control = CTRL_W'(ALU_SUB);
      ALUOP_R: begin
        case (funct3)
          F3_ADDSUB: control = funct7_5 ? CTRL_W'(ALU_SUB) : CTRL_W'(ALU_ADD);
          F3_AND:    control = CTRL_W'(ALU_AND);
          F3_OR:     control = CTRL_W'(ALU_OR);
          default:   control = CTRL_W'(ALU_ILLEGAL);
        endcase
      end
      ALUOP_I: begin
        // Immediate forms have no SUB; bit 30 is part of the immediate.
        case (funct3)
          F3_ADDSUB: control = CTRL_W'(ALU_ADD);
          F3_AND:    control = CTRL_W'(ALU_AND);
          F3_OR:     control = CTRL_W'(ALU_OR);
          default:   control = CTRL_W'(ALU_ILLEGAL);
        endcase
      end
      default: control = CTRL_W'(ALU_ILLEGAL);
    endcase
    illegal = (control == CTRL_W'(ALU_ILLEGAL));
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a bundle and presents control plus operands to
// the ALU through a two-entry skid buffer (main register M, skid register S).
// in_ready depends only on the skid valid flop, so out_ready never reaches
// in_ready combinationally.
// Optional build macro: ALU_ISSUE_PERF_CNT_EN adds issued/illegal counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_control,
  output logic [DATA_W-1:0] out_operand1,
  output logic [DATA_W-1:0] out_operand2,
`ifdef ALU_ISSUE_PERF_CNT_EN
  output logic [31:0]       issued_cnt,
  output logic [31:0]       illegal_cnt,
`endif
  output logic              out_illegal
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_ill;
  logic              accept;

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic              m_ill_q, m_ill_d, s_ill_q, s_ill_d;
  logic [DATA_W-1:0] m_op1_q, m_op1_d, s_op1_q, s_op1_d;
  logic [DATA_W-1:0] m_op2_q, m_op2_d, s_op2_q, s_op2_d;

  alu_op_decode #(.CTRL_W(CTRL_W)) u_dec (
    .aluop    (in_aluop),
    .funct3   (in_funct3),
    .funct7_5 (in_funct7_5),
    .control  (dec_ctrl),
    .illegal  (dec_ill)
  );

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready;

  // Skid-buffer next state: fill M first, spill into S while M is stalled,
  // and refill M from S before taking new input so order stays FIFO.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_ill_d   = m_ill_q;
    m_op1_d   = m_op1_q;
    m_op2_d   = m_op2_q;
    s_ctrl_d  = s_ctrl_q;
    s_ill_d   = s_ill_q;
    s_op1_d   = s_op1_q;
    s_op2_d   = s_op2_q;
    if (!m_valid_q) begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = dec_ctrl;
        m_ill_d   = dec_ill;
        m_op1_d   = in_op1;
        m_op2_d   = in_op2;
      end
    end else if (out_ready) begin
      if (s_valid_q) begin
        s_valid_d = 1'b0;
        m_ctrl_d  = s_ctrl_q;
        m_ill_d   = s_ill_q;
        m_op1_d   = s_op1_q;
        m_op2_d   = s_op2_q;
      end else if (accept) begin
        m_ctrl_d  = dec_ctrl;
        m_ill_d   = dec_ill;
        m_op1_d   = in_op1;
        m_op2_d   = in_op2;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = dec_ctrl;
      s_ill_d   = dec_ill;
      s_op1_d   = in_op1;
      s_op2_d   = in_op2;
    end
  end

  // Stage registers; reset discards anything in flight and zeroes outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_ill_q   <= 1'b0;
      m_op1_q   <= '0;
      m_op2_q   <= '0;
      s_ctrl_q  <= '0;
      s_ill_q   <= 1'b0;
      s_op1_q   <= '0;
      s_op2_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_ill_q   <= m_ill_d;
      m_op1_q   <= m_op1_d;
      m_op2_q   <= m_op2_d;
      s_ctrl_q  <= s_ctrl_d;
      s_ill_q   <= s_ill_d;
      s_op1_q   <= s_op1_d;
      s_op2_q   <= s_op2_d;
    end
  end

  assign out_valid    = m_valid_q;
  assign out_control  = m_ctrl_q;
  assign out_operand1 = m_op1_q;
  assign out_operand2 = m_op2_q;
  assign out_illegal  = m_ill_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] issued_cnt_q, issued_cnt_d;
  logic [31:0] illegal_cnt_q, illegal_cnt_d;

  // Count completed ALU handshakes; wraps naturally at 2^32.
  always_comb begin
    issued_cnt_d  = issued_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (m_valid_q && out_ready) begin
      issued_cnt_d = issued_cnt_q + 32'd1;
      if (m_ill_q) illegal_cnt_d = illegal_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      issued_cnt_q  <= issued_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign issued_cnt  = issued_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
